// File: rtl/gshare_btb_predictor_pkg.sv
// Shared definitions for the gshare/BTB branch predictor: 2-bit counter
// encodings and the saturating counter update.
package bp_pkg;

    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;
    localparam logic [1:0] CNT_INIT = CNT_WNT;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) nxt = cnt + 2'b01;
        end else begin
            if (cnt != CNT_SNT) nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_btb_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: fetch lookup, decode
// allocation and exec-stage counter update.
interface gshare_btb_predictor_if #(
    parameter int ADDR_W    = 32,
    parameter int ENTRIES   = 4,
    parameter int HIST_BITS = 4,
    parameter int IDX_W     = $clog2(ENTRIES)
);
    // No backpressure anywhere: d_is_branch and x_update are single-cycle
    // qualifiers that the predictor always accepts on the edge they are seen.
    logic [ADDR_W-1:0]    f_pc;
    logic [ADDR_W-1:0]    f_predict_addr;
    logic                 f_predict_valid;
    logic [ADDR_W-1:0]    d_pc;
    logic                 d_is_branch;
    logic [ADDR_W-1:0]    d_target_addr;
    logic [IDX_W-1:0]     d_entry;
    logic [HIST_BITS-1:0] d_hist;
    logic                 x_update;
    logic [IDX_W-1:0]     x_entry;
    logic [HIST_BITS-1:0] x_hist;
    logic                 x_taken;

    modport master (
        output f_pc, d_pc, d_is_branch, d_target_addr,
               x_update, x_entry, x_hist, x_taken,
        input  f_predict_addr, f_predict_valid, d_entry, d_hist
    );

    modport slave (
        input  f_pc, d_pc, d_is_branch, d_target_addr,
               x_update, x_entry, x_hist, x_taken,
        output f_predict_addr, f_predict_valid, d_entry, d_hist
    );
endinterface

// File: rtl/gshare_btb_predictor_pht.sv
// Per-entry pattern history tables of 2-bit saturating counters, indexed by
// (entry, global history). Clearing an entry overrides a same-cycle update.
module pattern_history_table
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 4,
    parameter int HIST_BITS = 4,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     i_rd_entry,
    input  logic [HIST_BITS-1:0] i_rd_hist,
    output logic                 o_rd_taken,
    input  logic                 i_upd_en,
    input  logic [IDX_W-1:0]     i_upd_entry,
    input  logic [HIST_BITS-1:0] i_upd_hist,
    input  logic                 i_upd_taken,
    input  logic                 i_clr_en,
    input  logic [IDX_W-1:0]     i_clr_entry
);
    localparam int DEPTH = 1 << HIST_BITS;

    logic [1:0] r_cnt [ENTRIES][DEPTH];

    assign o_rd_taken = r_cnt[i_rd_entry][i_rd_hist][1];

    // The clear is issued after the update so its nonblocking writes win
    // whenever both hit the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                for (int h = 0; h < DEPTH; h++) begin
                    r_cnt[e][h] <= CNT_INIT;
                end
            end
        end else begin
            if (i_upd_en) begin
                r_cnt[i_upd_entry][i_upd_hist] <=
                    sat_update(r_cnt[i_upd_entry][i_upd_hist], i_upd_taken);
            end
            if (i_clr_en) begin
                for (int h = 0; h < DEPTH; h++) begin
                    r_cnt[i_clr_entry][h] <= CNT_INIT;
                end
            end
        end
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Fully-associative BTB with gshare-style per-entry counters. Fetch lookups
// see state from before any same-cycle decode/exec writes.
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ENTRIES   = 4,
    parameter int HIST_BITS = 4,
    parameter int IDX_W     = $clog2(ENTRIES)
) (
    input logic clk,
    input logic reset,
    gshare_btb_predictor_if.slave bp
);
    logic [ENTRIES-1:0]   r_valid;
    logic [ADDR_W-1:0]    r_tag    [ENTRIES];
    logic [ADDR_W-1:0]    r_target [ENTRIES];
    logic [HIST_BITS-1:0] r_ghr;
    logic [IDX_W-1:0]     r_ptr;
    logic [ADDR_W-1:0]    r_f_addr;
    logic                 r_f_valid;
    logic [IDX_W-1:0]     r_d_entry;
    logic [HIST_BITS-1:0] r_d_hist;

    logic                 w_f_hit;
    logic [IDX_W-1:0]     w_f_idx;
    logic                 w_f_taken;
    logic                 w_d_hit;
    logic [IDX_W-1:0]     w_d_idx;
    logic                 w_alloc;

    always_comb begin
        w_f_hit = 1'b0;
        w_f_idx = '0;
        w_d_hit = 1'b0;
        w_d_idx = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (r_valid[e] && (r_tag[e] == bp.f_pc)) begin
                w_f_hit = 1'b1;
                w_f_idx = IDX_W'(e);
            end
            if (r_valid[e] && (r_tag[e] == bp.d_pc)) begin
                w_d_hit = 1'b1;
                w_d_idx = IDX_W'(e);
            end
        end
    end

    assign w_alloc = bp.d_is_branch && !w_d_hit;

    pattern_history_table #(
        .ENTRIES   (ENTRIES),
        .HIST_BITS (HIST_BITS),
        .IDX_W     (IDX_W)
    ) u_pht (
        .clk         (clk),
        .reset       (reset),
        .i_rd_entry  (w_f_idx),
        .i_rd_hist   (r_ghr),
        .o_rd_taken  (w_f_taken),
        .i_upd_en    (bp.x_update),
        .i_upd_entry (bp.x_entry),
        .i_upd_hist  (bp.x_hist),
        .i_upd_taken (bp.x_taken),
        .i_clr_en    (w_alloc),
        .i_clr_entry (r_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_tag[e]    <= '0;
                r_target[e] <= '0;
            end
            r_ghr     <= '0;
            r_ptr     <= '0;
            r_f_addr  <= '0;
            r_f_valid <= 1'b0;
            r_d_entry <= '0;
            r_d_hist  <= '0;
        end else begin
            // A fetch miss keeps the last predicted address on the output.
            if (w_f_hit) begin
                r_f_addr  <= r_target[w_f_idx];
                r_f_valid <= w_f_taken;
            end else begin
                r_f_valid <= 1'b0;
            end

            if (bp.d_is_branch) begin
                r_d_hist <= r_ghr;
                if (w_d_hit) begin
                    r_d_entry          <= w_d_idx;
                    r_target[w_d_idx]  <= bp.d_target_addr;
                end else begin
                    r_valid[r_ptr]  <= 1'b1;
                    r_tag[r_ptr]    <= bp.d_pc;
                    r_target[r_ptr] <= bp.d_target_addr;
                    r_d_entry       <= r_ptr;
                    r_ptr           <= r_ptr + 1'b1;
                end
            end

            if (bp.x_update) begin
                r_ghr <= {r_ghr[HIST_BITS-2:0], bp.x_taken};
            end
        end
    end

    assign bp.f_predict_addr  = r_f_addr;
    assign bp.f_predict_valid = r_f_valid;
    assign bp.d_entry         = r_d_entry;
    assign bp.d_hist          = r_d_hist;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed scoreboard bench for gshare_btb_predictor: drivers push expected
// outputs, a negedge monitor pops and compares them when they fall due.
module tb_gshare_btb_predictor;

  localparam int ADDR_W    = 32;
  localparam int ENTRIES   = 4;
  localparam int HIST_BITS = 4;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  gshare_btb_predictor_if #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .HIST_BITS(HIST_BITS)
  ) bp ();

  gshare_btb_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .HIST_BITS(HIST_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard entry: kind 0 = fetch, 1 = decode, 2 = all outputs zero
  typedef struct {
    int          due;
    int          kind;
    logic        fv;
    logic [31:0] fa;
    logic [1:0]  de;
    logic [3:0]  dh;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: stale expectation due %0d seen at %0d", e.name, e.due, cyc);
      end else if (e.kind == 0) begin
        chk({e.name, ".valid"}, {31'b0, bp.f_predict_valid}, {31'b0, e.fv});
        chk({e.name, ".addr"}, bp.f_predict_addr, e.fa);
      end else if (e.kind == 1) begin
        chk({e.name, ".entry"}, {30'b0, bp.d_entry}, {30'b0, e.de});
        chk({e.name, ".hist"}, {28'b0, bp.d_hist}, {28'b0, e.dh});
      end else begin
        chk({e.name, ".valid"}, {31'b0, bp.f_predict_valid}, 32'd0);
        chk({e.name, ".addr"}, bp.f_predict_addr, 32'd0);
        chk({e.name, ".entry"}, {30'b0, bp.d_entry}, 32'd0);
        chk({e.name, ".hist"}, {28'b0, bp.d_hist}, 32'd0);
      end
    end
  end

  // drivers
  task automatic step(input logic rst, input logic [31:0] fpc,
                      input logic dbr, input logic [31:0] dpc, input logic [31:0] dtgt,
                      input logic xu, input logic [1:0] xe, input logic [3:0] xh,
                      input logic xt);
    @(negedge clk);
    reset            = rst;
    bp.f_pc          = fpc;
    bp.d_is_branch   = dbr;
    bp.d_pc          = dpc;
    bp.d_target_addr = dtgt;
    bp.x_update      = xu;
    bp.x_entry       = xe;
    bp.x_hist        = xh;
    bp.x_taken       = xt;
  endtask

  task automatic fetch(input logic [31:0] fpc);
    step(1'b0, fpc, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic exp_f(input string name, input logic fv, input logic [31:0] fa);
    exp_t e;
    e = '{due: cyc + 1, kind: 0, fv: fv, fa: fa, de: 2'd0, dh: 4'd0, name: name};
    exp_q.push_back(e);
  endtask

  task automatic exp_d(input string name, input logic [1:0] de, input logic [3:0] dh);
    exp_t e;
    e = '{due: cyc + 1, kind: 1, fv: 1'b0, fa: 32'h0, de: de, dh: dh, name: name};
    exp_q.push_back(e);
  endtask

  task automatic exp_zero(input string name);
    exp_t e;
    e = '{due: cyc + 1, kind: 2, fv: 1'b0, fa: 32'h0, de: 2'd0, dh: 4'd0, name: name};
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    bp.f_pc = '0; bp.d_pc = '0; bp.d_is_branch = 1'b0; bp.d_target_addr = '0;
    bp.x_update = 1'b0; bp.x_entry = '0; bp.x_hist = '0; bp.x_taken = 1'b0;

    step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0);
    step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_zero("reset");

    fetch(32'h100); exp_f("fetch_100_after_reset", 1'b0, 32'h0);
    fetch(32'h0);   exp_f("fetch_0_after_reset", 1'b0, 32'h0);

    // allocate 0x100 -> entry 0, counters weakly not-taken
    step(1'b0, 32'h0, 1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_d("alloc_e0", 2'd0, 4'd0); exp_f("miss_during_alloc", 1'b0, 32'h0);
    fetch(32'h100); exp_f("hit_weak_nt", 1'b0, 32'h200);

    // three taken updates to counter[0][0]; fetch reads counters at ghr 0,1,3
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 4'd0, 1'b1);
      exp_f("fetch_during_train", 1'b0, 32'h200);
    end
    step(1'b0, 32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_f("hist_index_0111", 1'b0, 32'h200); exp_d("ghr_0111", 2'd0, 4'd7);

    // four not-taken updates drive ghr back to 0; fetch misses hold the address
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 4'd0, 1'b0);
      exp_f("miss_holds_addr", 1'b0, 32'h200);
    end
    fetch(32'h100); exp_f("strong_taken_hist0", 1'b1, 32'h200);

    // fill the remaining entries and wrap onto entry 0
    step(1'b0, 32'h0, 1'b1, 32'h104, 32'h204, 1'b0, 2'd0, 4'd0, 1'b0); exp_d("alloc_104", 2'd1, 4'd0);
    step(1'b0, 32'h0, 1'b1, 32'h108, 32'h208, 1'b0, 2'd0, 4'd0, 1'b0); exp_d("alloc_108", 2'd2, 4'd0);
    step(1'b0, 32'h0, 1'b1, 32'h10C, 32'h20C, 1'b0, 2'd0, 4'd0, 1'b0); exp_d("alloc_10c", 2'd3, 4'd0);
    step(1'b0, 32'h0, 1'b1, 32'h110, 32'h210, 1'b0, 2'd0, 4'd0, 1'b0); exp_d("alloc_110_wrap", 2'd0, 4'd0);
    fetch(32'h100); exp_f("evicted_100_miss", 1'b0, 32'h200);
    step(1'b0, 32'h110, 1'b1, 32'h110, 32'h210, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_f("hit_110_cleared_cnt", 1'b0, 32'h210); exp_d("hit_110_entry", 2'd0, 4'd0);

    // allocation of entry 1 and exec update of entry 1 in the same cycle
    step(1'b0, 32'h0, 1'b1, 32'h120, 32'h220, 1'b1, 2'd1, 4'd0, 1'b1);
    exp_d("alloc_with_update", 2'd1, 4'd0);
    step(1'b0, 32'h120, 1'b1, 32'h120, 32'h220, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_d("ghr_shifted_1", 2'd1, 4'd1); exp_f("e1_hist1", 1'b0, 32'h220);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd3, 4'd5, 1'b0);
      exp_f("ghr_flush", 1'b0, 32'h220);
    end
    fetch(32'h120); exp_f("update_dropped", 1'b0, 32'h220);
    // one taken update on cleared counter[1][0]: 01 -> 10
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 4'd0, 1'b1);
    exp_f("idle_miss", 1'b0, 32'h220);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd3, 4'd5, 1'b0);
      exp_f("ghr_flush2", 1'b0, 32'h220);
    end
    fetch(32'h120); exp_f("e1_cleared_then_taken", 1'b1, 32'h220);

    // reset mid-stream with every input active
    step(1'b1, 32'h110, 1'b1, 32'h130, 32'h230, 1'b1, 2'd0, 4'd0, 1'b1);
    exp_zero("mid_reset");
    fetch(32'h110); exp_f("post_reset_110_miss", 1'b0, 32'h0);
    fetch(32'h120); exp_f("post_reset_120_miss", 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 32'h110, 32'h210, 1'b0, 2'd0, 4'd0, 1'b0);
    exp_f("post_reset_100_miss", 1'b0, 32'h0); exp_d("post_reset_ptr0", 2'd0, 4'd0);
    fetch(32'h110); exp_f("post_reset_realloc_hit", 1'b0, 32'h210);

    fetch(32'h0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
Name: gshare_btb_predictor

Overview:
- Parametrised branch-target predictor for the fetch/decode/exec pipeline.
- Combines a fully-associative branch target buffer (BTB) with per-entry pattern history tables (PHTs) of 2-bit saturating counters, indexed by a global history register.
- Next generation of the team's branch predictor:
  - Configurable depth, history length and address width.
  - Explicit valid bits.
  - Explicit reset.
  - Update path tagged by the exec stage, so no internal delay lines are needed.

Parameters:
ADDR_W, 32, PC/target address width
ENTRIES, 4, BTB entries (power of 2, >=2)
HIST_BITS, 4, global history length; each entry owns 2**HIST_BITS counters
IDX_W, $clog2(ENTRIES), derived entry index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
f_pc  in  ADDR_W  fetch PC to look up
f_predict_addr  out  ADDR_W  registered predicted target
f_predict_valid  out  1  registered: BTB hit and counter predicts taken
d_pc  in  ADDR_W  PC of decoded instruction
d_is_branch  in  1  decoded instruction is a branch
d_target_addr  in  ADDR_W  decoded branch target
d_entry  out  IDX_W  registered entry allocated/matched for d_pc; carried down the pipeline
d_hist  out  HIST_BITS  registered history snapshot for d_pc; carried down the pipeline
x_update  in  1  exec-stage branch resolved this cycle
x_entry  in  IDX_W  entry to update (returned d_entry)
x_hist  in  HIST_BITS  history used (returned d_hist)
x_taken  in  1  actual branch outcome

Behaviour:
- Reset (sync, active-high) sets:
  - all valid bits, tags and targets to 0
  - every counter to 2'b01 (weakly not-taken)
  - global history to 0
  - replacement pointer to 0
  - all registered outputs (f_predict_*, d_entry, d_hist) to 0
- Reset takes priority over every other input in the same cycle.
- Fetch (1-cycle latency):
  - At each posedge, compare f_pc with all valid tags.
  - On a hit at entry e:
    - f_predict_addr <= target[e]
    - f_predict_valid <= counter[e][ghr][1]
  - On a miss:
    - f_predict_valid <= 0
    - f_predict_addr holds its previous value
  - Multiple matches cannot occur, because allocation checks for a hit first.
- Decode (when d_is_branch=1):
  - Hit on valid entry e:
    - d_entry <= e
    - target[e] <= d_target_addr (refresh)
  - Miss:
    - Allocate at the replacement pointer p: tag <= d_pc, target <= d_target_addr, valid <= 1, all 2**HIST_BITS counters of p <= 2'b01.
    - d_entry <= p.
    - p <= p+1, wrapping from ENTRIES-1 to 0.
  - d_hist <= current ghr in both cases.
  - When d_is_branch=0, d_entry and d_hist hold their values.
- Exec (when x_update=1):
  - counter[x_entry][x_hist] saturating-increments if x_taken=1, else decrements; stays at 2'b11 / 2'b00 at the limits.
  - ghr <= {ghr[HIST_BITS-2:0], x_taken}.
  - The update applies even if the entry was since reallocated (accepted aliasing).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the MSB.
- Simultaneous events in one cycle:
  - Fetch reads old state (read-before-write), including target, counters and ghr.
  - Decode allocation and exec update target the same entry: the allocation wins, all of that entry's counters become 01 and the exec counter update is dropped; ghr still shifts.
  - Decode and exec in the same cycle: d_hist captures the pre-shift ghr.
- All state is updated with nonblocking assignments. There are no combinational paths from inputs to outputs.

Decomposition:
- Package bp_pkg:
  - counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST
  - CNT_INIT = CNT_WNT
  - function sat_update(cnt, taken)
- Sub-module pattern_history_table (ENTRIES, HIST_BITS):
  - holds the counter array
  - one read port (entry, hist -> taken bit)
  - one update port (entry, hist, taken)
  - one entry-clear port
  - implements the clear-over-update priority

Test Plan:
- Reset then f_pc=0x100 -> next cycle f_predict_valid=0 and f_predict_addr=0. Also check f_pc=0 after reset -> no hit, because the valid bits are clear.
- Decode branch d_pc=0x100, d_target_addr=0x200 -> d_entry=0 and d_hist=0. Fetch 0x100 next -> f_predict_addr=0x200 with f_predict_valid=0 (counter 01).
- Three x_update (entry 0, hist 0, taken=1) -> counter goes 01->10->11->11 (saturates); ghr=4'b0111. Fetch 0x100 then predicts valid only if counter[0][0111] is taken: expect 0, confirming history indexing.
- Allocate ENTRIES+1 distinct PCs 0x100,0x104,...,0x110 -> the fifth overwrites entry 0; fetch 0x100 misses and fetch 0x110 hits with d_entry=0.
- Same cycle: d_is_branch miss allocating entry 1 plus x_update entry 1 taken -> all entry-1 counters read 01 afterwards and ghr still shifts in 1.
- Assert reset mid-stream with valid entries -> next cycle all outputs are 0 and every previously stored PC misses.
